hsi_msg_sched: RTL and testbench

HSI_MSG_SCHED -- requirements
Module: hsi_msg_sched

---
 rtl/hsi_msg_sched_if.sv | 29 ++
 rtl/hsi_msg_sched.sv | 174 +++++++++++++++++
 tb/tb_hsi_msg_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsi_msg_sched_if.sv
// hsi_msg_sched_if
//   Bundles the source-side handshake (req/grant/data/strobes) and the
//   coder-side byte path (q/q_rdy/cd_busy) of the HSI message scheduler.
//   Parameter N_SRC must match the scheduler instance.
//   Modports:
//     master : the scheduler (drives grant, q, q_rdy)
//     slave  : sources + coder (drive req, src_d, src_d_rdy, src_msg_end, cd_busy)
interface hsi_msg_sched_if #(
  parameter int N_SRC = 5
);
  logic [N_SRC-1:0]   req;
  logic [N_SRC-1:0]   grant;
  logic [8*N_SRC-1:0] src_d;
  logic [N_SRC-1:0]   src_d_rdy;
  logic [N_SRC-1:0]   src_msg_end;
  logic               cd_busy;
  logic [7:0]         q;
  logic               q_rdy;

  modport master (
    input  req, src_d, src_d_rdy, src_msg_end, cd_busy,
    output grant, q, q_rdy
  );

  modport slave (
    output req, src_d, src_d_rdy, src_msg_end, cd_busy,
    input  grant, q, q_rdy
  );
endinterface

// File: rtl/hsi_msg_sched.sv
// hsi_msg_sched
//   Arbitrates between N_SRC message sources, forwards the granted source's
//   payload bytes to the coder, then appends a CRC16-CCITT (poly 0x1021,
//   init 0xFFFF, MSB first) as two bytes, high byte first. A message longer
//   than MAX_LEN bytes is cut off with an overrun pulse and still gets its CRC.
//   Ports:
//     clk      : system clock, rising edge
//     n_rst    : asynchronous active-low reset
//     hsi      : hsi_msg_sched_if.master (req/grant/src_* in, q/q_rdy out, cd_busy in)
//     busy     : high whenever the FSM is not in IDLE
//     overrun  : one-cycle strobe on forced termination at MAX_LEN
//   Build option:
//     HSI_SCHED_ROUND_ROBIN_EN defined   -> round-robin arbitration
//     HSI_SCHED_ROUND_ROBIN_EN undefined -> fixed priority, lowest index wins
//
//   state  | meaning
//   IDLE   | no message; arbitrate when any req is high
//   SEND   | forwarding payload bytes of the granted source
//   CRC_HI | waiting to emit CRC[15:8]
//   CRC_LO | waiting to emit CRC[7:0], then release grant
module hsi_msg_sched #(
  parameter int N_SRC   = 5,
  parameter int MAX_LEN = 64
) (
  input  logic            clk,
  input  logic            n_rst,
  hsi_msg_sched_if.master hsi,
  output logic            busy,
  output logic            overrun
);

  localparam int PTR_W = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, SEND, CRC_HI, CRC_LO} state_t;

  state_t           state_q;
  logic [N_SRC-1:0] grant_q;
  logic [N_SRC-1:0] pick;
  logic [7:0]       q_q;
  logic             q_rdy_q;
  logic             overrun_q;
  logic [15:0]      crc_q;
  logic [7:0]       cnt_q;
  logic [7:0]       sel_d;
  logic             byte_stb;
  logic             end_stb;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Strobes from non-granted sources are masked off here.
  assign byte_stb = |(hsi.src_d_rdy & grant_q);
  assign end_stb  = |(hsi.src_msg_end & grant_q);

  always_comb begin
    sel_d = 8'h00;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) sel_d = sel_d | hsi.src_d[8*i +: 8];
    end
  end

`ifdef HSI_SCHED_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] pick_idx;
  logic             found;

  // Search order: rr_ptr+1, rr_ptr+2, ... wrapping modulo N_SRC.
  always_comb begin
    pick     = '0;
    pick_idx = rr_ptr_q;
    found    = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (!found && hsi.req[i] && (i == (int'(rr_ptr_q) + k) % N_SRC)) begin
          pick[i]  = 1'b1;
          pick_idx = PTR_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr_q <= PTR_W'(N_SRC - 1);
    end else if (state_q == IDLE && |hsi.req) begin
      rr_ptr_q <= pick_idx;
    end
  end
`else
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && hsi.req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      q_q       <= 8'h00;
      q_rdy_q   <= 1'b0;
      overrun_q <= 1'b0;
      crc_q     <= 16'hFFFF;
      cnt_q     <= 8'h00;
    end else begin
      q_rdy_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|hsi.req) begin
            grant_q <= pick;
            crc_q   <= 16'hFFFF;
            cnt_q   <= 8'h00;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (byte_stb) begin
            q_q     <= sel_d;
            q_rdy_q <= 1'b1;
            crc_q   <= crc_byte(crc_q, sel_d);
            cnt_q   <= cnt_q + 8'd1;
          end
          // A byte arriving with the end strobe is forwarded above first.
          if (end_stb) begin
            state_q <= CRC_HI;
          end else if (byte_stb && cnt_q == 8'(MAX_LEN - 1)) begin
            overrun_q <= 1'b1;
            state_q   <= CRC_HI;
          end
        end
        // q_rdy_q low guarantees a gap cycle between consecutive coder bytes.
        CRC_HI: begin
          if (!hsi.cd_busy && !q_rdy_q) begin
            q_q     <= crc_q[15:8];
            q_rdy_q <= 1'b1;
            state_q <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (!hsi.cd_busy && !q_rdy_q) begin
            q_q     <= crc_q[7:0];
            q_rdy_q <= 1'b1;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hsi.grant = grant_q;
  assign hsi.q     = q_q;
  assign hsi.q_rdy = q_rdy_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hsi_msg_sched.sv
module tb_hsi_msg_sched;
  localparam int N  = 5;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic busy;
  logic overrun;

  hsi_msg_sched_if #(.N_SRC(N)) ifc ();

  hsi_msg_sched #(.N_SRC(N), .MAX_LEN(ML)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .hsi     (ifc.master),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ovr_cnt = 0;
  logic [7:0] q_log[$];
  int t_log[$];

  // Coder-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (ifc.q_rdy === 1'b1) begin
      q_log.push_back(ifc.q);
      t_log.push_back(cyc);
    end
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    q_log.delete();
    t_log.delete();
    ovr_cnt = 0;
  endtask

  task automatic idle_inputs();
    ifc.req         = '0;
    ifc.src_d       = '0;
    ifc.src_d_rdy   = '0;
    ifc.src_msg_end = '0;
    ifc.cd_busy     = 1'b0;
  endtask

  // One-cycle strobe on one source; called just after a rising edge.
  task automatic strobe(input int src, input logic [7:0] d, input bit rdy, input bit last);
    ifc.src_d[8*src +: 8] = d;
    ifc.src_d_rdy[src]    = rdy;
    ifc.src_msg_end[src]  = last;
    tick();
    ifc.src_d_rdy   = '0;
    ifc.src_msg_end = '0;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp_g, input string name);
    int n = 0;
    while (ifc.grant === '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.grant !== exp_g) begin
      errors++;
      $display("FAIL %s: grant=%b expected %b", name, ifc.grant, exp_g);
    end
  endtask

  // Returns one cycle after busy falls so the last CRC byte is logged.
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b expected 0 within 100 cycles", name, busy);
    end
    tick();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    idle_inputs();
    ifc.req = 5'b00001;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifc.grant !== 5'b0) begin errors++; $display("FAIL rst_grant: got %b expected 00000", ifc.grant); end
    checks++; if (ifc.q !== 8'h00) begin errors++; $display("FAIL rst_q: got %h expected 00", ifc.q); end
    checks++; if (ifc.q_rdy !== 1'b0) begin errors++; $display("FAIL rst_q_rdy: got %b expected 0", ifc.q_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    ifc.req = '0;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_idle();
    ifc.req = '0;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    checks++; if (ifc.grant !== 5'b0) begin errors++; $display("FAIL idle_grant: got %b expected 00000", ifc.grant); end
  endtask

  // "123" from source 0; CRC16-CCITT (0x1021, init FFFF, MSB first) of "123" is 0x5BCE.
  task automatic test_basic();
    logic [7:0] exp_b [5] = '{8'h31, 8'h32, 8'h33, 8'h5B, 8'hCE};
    clr_log();
    ifc.req = 5'b00001;
    wait_grant(5'b00001, "basic_grant");
    ifc.req = '0;
    strobe(1, 8'hEE, 1'b1, 1'b1);
    strobe(0, 8'h31, 1'b1, 1'b0);
    strobe(0, 8'h32, 1'b1, 1'b0);
    strobe(0, 8'h33, 1'b1, 1'b0);
    strobe(0, 8'h00, 1'b0, 1'b1);
    wait_idle("basic_idle");
    checks++; if (q_log.size() != 5) begin errors++; $display("FAIL basic_len: got %0d bytes expected 5", q_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= q_log.size() || q_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h expected %h", i, (i < q_log.size()) ? q_log[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (ifc.grant !== 5'b0) begin errors++; $display("FAIL basic_grant_clr: got %b expected 00000", ifc.grant); end
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL basic_overrun: got %0d pulses expected 0", ovr_cnt); end
  endtask

  // Byte and end together; CRC of 0xAA alone is 0xF550.
  task automatic test_end_with_byte();
    logic [7:0] exp_b [3] = '{8'hAA, 8'hF5, 8'h50};
    clr_log();
    ifc.req = 5'b00100;
    wait_grant(5'b00100, "endbyte_grant");
    ifc.req = '0;
    strobe(2, 8'hAA, 1'b1, 1'b1);
    wait_idle("endbyte_idle");
    checks++; if (q_log.size() != 3) begin errors++; $display("FAIL endbyte_len: got %0d bytes expected 3", q_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_log.size() || q_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL endbyte_byte%0d: got %h expected %h", i, (i < q_log.size()) ? q_log[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  // MAX_LEN=4: "123456" sent without end; CRC of "1234" is 0x5349.
  // cd_busy stays high during the payload, which must not stall it.
  task automatic test_overrun();
    logic [7:0] exp_b [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h53, 8'h49};
    clr_log();
    ifc.req = 5'b00010;
    wait_grant(5'b00010, "ovr_grant");
    ifc.req = '0;
    ifc.cd_busy = 1'b1;
    for (int i = 0; i < 6; i++) strobe(1, 8'(8'h31 + i), 1'b1, 1'b0);
    ifc.cd_busy = 1'b0;
    wait_idle("ovr_idle");
    checks++; if (q_log.size() != 6) begin errors++; $display("FAIL ovr_len: got %0d bytes expected 6", q_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= q_log.size() || q_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL ovr_byte%0d: got %h expected %h", i, (i < q_log.size()) ? q_log[i] : 8'hxx, exp_b[i]);
      end
    end
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt); end
  endtask

  task automatic test_cd_busy();
    logic [7:0] exp_b [3] = '{8'hAA, 8'hF5, 8'h50};
    clr_log();
    ifc.req = 5'b01000;
    wait_grant(5'b01000, "cdb_grant");
    ifc.req = '0;
    ifc.cd_busy = 1'b1;
    strobe(3, 8'hAA, 1'b1, 1'b1);
    repeat (10) tick();
    checks++; if (q_log.size() != 1) begin errors++; $display("FAIL cdb_hold: got %0d bytes while busy expected 1", q_log.size()); end
    ifc.cd_busy = 1'b0;
    wait_idle("cdb_idle");
    checks++; if (q_log.size() != 3) begin errors++; $display("FAIL cdb_len: got %0d bytes expected 3", q_log.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= q_log.size() || q_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL cdb_byte%0d: got %h expected %h", i, (i < q_log.size()) ? q_log[i] : 8'hxx, exp_b[i]);
      end
    end
    if (t_log.size() >= 3) begin
      checks++;
      if (t_log[2] - t_log[1] < 2) begin
        errors++;
        $display("FAIL cdb_gap: got %0d cycles between CRC bytes expected >=2", t_log[2] - t_log[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [5] = '{8'h31, 8'h32, 8'h33, 8'h5B, 8'hCE};
    clr_log();
    ifc.req = 5'b00001;
    wait_grant(5'b00001, "rstmid_grant");
    ifc.req = '0;
    strobe(0, 8'h31, 1'b1, 1'b0);
    strobe(0, 8'h32, 1'b1, 1'b0);
    n_rst = 1'b0;
    #1;
    checks++; if (ifc.grant !== 5'b0) begin errors++; $display("FAIL rstmid_grant_clr: got %b expected 00000", ifc.grant); end
    checks++; if (ifc.q !== 8'h00) begin errors++; $display("FAIL rstmid_q: got %h expected 00", ifc.q); end
    checks++; if (ifc.q_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_q_rdy: got %b expected 0", ifc.q_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
    clr_log();
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    checks++; if (q_log.size() != 0) begin errors++; $display("FAIL rstmid_no_q: got %0d bytes after reset expected 0", q_log.size()); end
    ifc.req = 5'b00001;
    wait_grant(5'b00001, "rstmid_grant2");
    ifc.req = '0;
    strobe(0, 8'h31, 1'b1, 1'b0);
    strobe(0, 8'h32, 1'b1, 1'b0);
    strobe(0, 8'h33, 1'b1, 1'b1);
    wait_idle("rstmid_idle");
    checks++; if (q_log.size() != 5) begin errors++; $display("FAIL rstmid_len: got %0d bytes expected 5", q_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= q_log.size() || q_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL rstmid_byte%0d: got %h expected %h", i, (i < q_log.size()) ? q_log[i] : 8'hxx, exp_b[i]);
      end
    end
  endtask

  // req=10101 held across three empty messages (CRC FFFF each).
  task automatic test_arbitration();
    logic [N-1:0] exp_g [3];
`ifdef HSI_SCHED_ROUND_ROBIN_EN
    exp_g = '{5'b00001, 5'b00100, 5'b10000};
`else
    exp_g = '{5'b00001, 5'b00001, 5'b00001};
`endif
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    clr_log();
    ifc.req = 5'b10101;
    for (int m = 0; m < 3; m++) begin
      wait_grant(exp_g[m], $sformatf("arb_grant%0d", m));
      if (m == 2) ifc.req = '0;
      ifc.src_msg_end = '1;
      tick();
      ifc.src_msg_end = '0;
      wait_idle($sformatf("arb_idle%0d", m));
    end
    checks++; if (ifc.grant !== 5'b0) begin errors++; $display("FAIL arb_final_grant: got %b expected 00000", ifc.grant); end
    checks++; if (q_log.size() != 6) begin errors++; $display("FAIL arb_len: got %0d bytes expected 6", q_log.size()); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_end_with_byte();
    test_overrun();
    test_cd_busy();
    test_reset_mid();
    test_arbitration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
